// File: rtl/ascii2score_parser_if.sv
// Character-in / score-out handshake bundle for ascii2score_parser.
// master: the character source and score consumer side.
// slave:  the parser itself.
interface ascii2score_parser_if;
  logic [6:0] ascii_in;
  logic       ascii_valid;
  logic       ascii_ready;
  logic [6:0] score;
  logic       score_valid;
  logic       score_ready;
  logic       error;

  modport master (
    output ascii_in, ascii_valid, score_ready,
    input  ascii_ready, score, score_valid, error
  );

  modport slave (
    input  ascii_in, ascii_valid, score_ready,
    output ascii_ready, score, score_valid, error
  );
endinterface

// File: rtl/ascii2score_parser.sv
// ascii2score_parser: turns a frame of up to two ASCII digits followed by
// TERM_CHAR into a binary score 0..99 on a valid/ready output.
// Malformed frames (empty, non-digit, three or more digits) produce a
// one-cycle error pulse after their terminator and no score.
// Optional feature macro: ASCII2SCORE_SPACE_SKIP_EN -- when defined, spaces
// received between frames (in IDLE) are dropped instead of spoiling the frame.
module ascii2score_parser #(
  parameter logic [6:0] TERM_CHAR = 7'h0D
) (
  input  logic                  clk,
  input  logic                  rst,
  ascii2score_parser_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ONE  = 3'd1,
    S_TWO  = 3'd2,
    S_SKIP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [6:0] CH_0     = 7'h30;
  localparam logic [6:0] CH_9     = 7'h39;
  localparam logic [6:0] CH_SPACE = 7'h20;

  state_t     state, state_nxt;
  logic [6:0] acc, acc_nxt;
  logic [6:0] score_q, score_nxt;
  logic       err_q, err_nxt;

  logic       xfer;
  logic       is_digit;
  logic       is_term;
  logic [6:0] dval;
  logic [6:0] acc_mac;

  // Character classification and the decimal shift-in; acc is at most 9
  // whenever acc_mac is used, so the result stays within 99.
  always_comb begin
    is_digit = (bus.ascii_in >= CH_0) && (bus.ascii_in <= CH_9);
    is_term  = (bus.ascii_in == TERM_CHAR);
    dval     = bus.ascii_in - CH_0;
    acc_mac  = (acc << 3) + (acc << 1) + dval;
  end

  // Handshake outputs come straight from the state register.
  assign bus.ascii_ready = (state != S_DONE);
  assign bus.score_valid = (state == S_DONE);
  assign bus.score       = score_q;
  assign bus.error       = err_q;
  assign xfer            = bus.ascii_valid && bus.ascii_ready;

  // Next-state logic: only an accepted character (or a consumed score)
  // moves the machine.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    score_nxt = score_q;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (xfer) begin
          if (is_digit) begin
            acc_nxt   = dval;
            state_nxt = S_ONE;
          end else if (is_term) begin
            err_nxt   = 1'b1;                 // empty frame
          end
`ifdef ASCII2SCORE_SPACE_SKIP_EN
          else if (bus.ascii_in == CH_SPACE) begin
            state_nxt = S_IDLE;               // leading padding is dropped
          end
`endif
          else begin
            state_nxt = S_SKIP;
          end
        end
      end
      S_ONE: begin
        if (xfer) begin
          if (is_digit) begin
            acc_nxt   = acc_mac;
            state_nxt = S_TWO;
          end else if (is_term) begin
            score_nxt = acc;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_SKIP;
          end
        end
      end
      S_TWO: begin
        if (xfer) begin
          if (is_term) begin
            score_nxt = acc;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_SKIP;               // third digit or junk
          end
        end
      end
      S_SKIP: begin
        if (xfer && is_term) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        if (bus.score_ready) begin
          acc_nxt   = '0;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        acc_nxt   = '0;
      end
    endcase
  end

  // State, accumulator, result and error-pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      acc     <= '0;
      score_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      score_q <= score_nxt;
      err_q   <= err_nxt;
    end
  end

endmodule

// File: doc/ascii2score_parser.md
# ascii2score_parser

Parses a stream of 7-bit ASCII characters into a binary score in the range 0–99. It is the inverse of the score-to-ASCII path: that path renders a score as two digit characters, and this block turns digit characters back into a value. It sits between a character source (UART receiver, keyboard/command FIFO) and the game-state logic. Characters arrive on a valid/ready handshake, and each parsed score is presented on a valid/ready output.

## Interface
Parameters:
- TERM_CHAR, 7'h0D: frame terminator character (CR).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low; while low, all registers are held at reset values.
- ascii_in  in  7  input character.
- ascii_valid  in  1  ascii_in is valid.
- ascii_ready  out  1  block accepts a character. A transfer occurs when ascii_valid && ascii_ready on a rising edge.
- score  out  7  parsed score, 0–99. Registered.
- score_valid  out  1  score holds an unconsumed result.
- score_ready  in  1  consumer accepts score. A transfer occurs when score_valid && score_ready.
- error  out  1  single-cycle pulse when a malformed frame is terminated.

## Operation
- Digit: ascii_in in 7'h30–7'h39, value d = ascii_in − 7'h30. Any character other than a digit or TERM_CHAR is "other".
- Accumulator acc, 7 bits. The update acc*10+d has a maximum of 99, so it never exceeds 7 bits.
- The FSM acts only on accepted characters. No state change occurs without a transfer.
  - IDLE: digit → acc=d, go to ONE. TERM_CHAR → pulse error, stay in IDLE (empty frame). Other → go to SKIP.
  - ONE: digit → acc=acc*10+d, go to TWO. TERM_CHAR → score=acc, go to DONE. Other → go to SKIP.
  - TWO: TERM_CHAR → score=acc, go to DONE. Digit (third digit, overflow) → go to SKIP. Other → go to SKIP.
  - SKIP: TERM_CHAR → pulse error, go to IDLE. Anything else is discarded, stay in SKIP.
  - DONE: score_valid=1 and ascii_ready=0. On a score transfer → go to IDLE and clear acc.
- ascii_ready = (state != DONE), decoded combinationally from the state register.
- score_valid = (state == DONE).
- score holds its last value until the next successful frame. It is not cleared on consume.
- Leading zeros are legal: "0","7",CR gives 7.

## Timing
- Reset values: score=0, score_valid=0, error=0, ascii_ready=1, state=IDLE, acc=0.
- Latency: score_valid rises the cycle after the terminator transfer edge. error is high for exactly the one cycle after the terminator transfer that ended a bad frame.
- Back-to-back input: one character per cycle in IDLE, ONE, TWO and SKIP. A terminator that completes a good frame is followed by at least one cycle with ascii_ready=0.
- Throughput: the minimum for a good frame "d",CR is 2 input cycles plus 1 DONE cycle when score_ready is tied high.
- Output backpressure: while score_ready is low in DONE, score and score_valid are stable and ascii_ready stays 0.
- score_ready while not in DONE is ignored.
- Reset asserted mid-frame or in DONE: immediate (asynchronous) return to the reset values. The partial frame is lost and no error pulse is generated.
- ascii_valid may drop without a transfer. The FSM state is unaffected.

## Configuration
- ASCII2SCORE_SPACE_SKIP_EN
  - Defined: a space (7'h20) accepted in IDLE is discarded and the state stays IDLE, so " 42",CR gives 42. Spaces in ONE or TWO still go to SKIP.
  - Undefined: a space is "other" in every state, so " 42",CR gives an error pulse and no score.

## Test plan
- "4","2",CR with valid held high and score_ready=1 → score=42, score_valid high for 1 cycle, error never asserted.
- "9","9",CR, then "5",CR back-to-back → score=99, then score=5. ascii_ready is low exactly during each DONE cycle.
- "1","2","3",CR → error pulses 1 cycle after CR, score_valid stays 0, score retains its previous value. A following "7",CR gives 7.
- CR alone, and "A","3",CR → one error pulse each, state returns to IDLE.
- "3","1",CR with score_ready low for 5 cycles → score=31 and score_valid stable, ascii_ready=0 throughout; released on the cycle score_ready rises.
- rst pulled low after "5" → all outputs at reset values. Then " 8",CR gives score=8 with ASCII2SCORE_SPACE_SKIP_EN defined, and an error pulse without it.
